// File: rtl/shift_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_loader : serialises a parallel word (or issues a fill) into the
//                downstream parameterised shift register.
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
module shift_loader #(
  parameter int OUTPUT_LENGTH = 10,
  parameter int CNT_W         = $clog2(OUTPUT_LENGTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OUTPUT_LENGTH-1:0] data_in,
  input  logic                     data_dir,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic                     fill_valid,
  input  logic                     fill_bit,
  output logic                     serial_out,
  output logic [1:0]               control_signal,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         bit_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]       c_ctl_hold  = 2'b00;
  localparam logic [1:0]       c_ctl_left  = 2'b01;
  localparam logic [1:0]       c_ctl_right = 2'b10;
  localparam logic [1:0]       c_ctl_load  = 2'b11;
  localparam logic [CNT_W-1:0] c_last_idx  = CNT_W'(OUTPUT_LENGTH - 1);

  state_t                   state_q, state_d;
  logic [OUTPUT_LENGTH-1:0] word_q, word_d;
  logic                     dir_q, dir_d;
  logic                     serial_q, serial_d;
  logic [1:0]               ctl_q, ctl_d;
  logic                     done_q, done_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OUTPUT_LENGTH-1:0] w_shifted;

  // The captured word is consumed from the end being transmitted, so the
  // next bit always sits at a fixed position.
  assign w_shifted = dir_q ? (word_q >> 1) : (word_q << 1);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    dir_d    = dir_q;
    serial_d = 1'b0;
    ctl_d    = c_ctl_hold;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_valid) begin
          state_d  = ST_FILL;
          ctl_d    = c_ctl_load;
          serial_d = fill_bit;
        end else if (data_valid) begin
          state_d  = ST_SHIFT;
          word_d   = data_in;
          dir_d    = data_dir;
          cnt_d    = '0;
          ctl_d    = data_dir ? c_ctl_right : c_ctl_left;
          serial_d = data_dir ? data_in[0] : data_in[OUTPUT_LENGTH-1];
        end
      end
      ST_SHIFT: begin
        if (cnt_q == c_last_idx) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          word_d   = w_shifted;
          ctl_d    = dir_q ? c_ctl_right : c_ctl_left;
          serial_d = dir_q ? w_shifted[0] : w_shifted[OUTPUT_LENGTH-1];
        end
      end
      ST_FILL: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      dir_q    <= 1'b0;
      serial_q <= 1'b0;
      ctl_q    <= c_ctl_hold;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      dir_q    <= dir_d;
      serial_q <= serial_d;
      ctl_q    <= ctl_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_ready     = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign serial_out     = serial_q;
  assign control_signal = ctl_q;
  assign done           = done_q;
  assign bit_count      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_shift_loader : directed + randomised bench for shift_loader with a
//                   behavioural model of the downstream shift register.
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_shift_loader;
  localparam int N  = 10;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  data_in;
  logic          data_dir;
  logic          data_valid;
  logic          data_ready;
  logic          fill_valid;
  logic          fill_bit;
  logic          serial_out;
  logic [1:0]    control_signal;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [N-1:0]  model_reg   = '0;

  shift_loader #(.OUTPUT_LENGTH(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_dir       (data_dir),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .fill_valid     (fill_valid),
    .fill_bit       (fill_bit),
    .serial_out     (serial_out),
    .control_signal (control_signal),
    .busy           (busy),
    .done           (done),
    .bit_count      (bit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd_word();
    logic [31:0] r;
    r = $urandom;
    return r[N-1:0];
  endfunction

  // Downstream register behaviour, then advance to 1 time unit after the edge.
  task automatic tick();
    case (control_signal)
      2'b01:   model_reg = {model_reg[N-2:0], serial_out};
      2'b10:   model_reg = {serial_out, model_reg[N-1:1]};
      2'b11:   model_reg = {N{serial_out}};
      default: model_reg = model_reg;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_shift(input logic [N-1:0] word, input logic dir,
                          input bit keep_valid, input bit noise);
    logic [N-1:0] tmp;
    logic [31:0]  r;
    chk("idle_ready", 32'(data_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    data_valid = 1'b1;
    data_in    = word;
    data_dir   = dir;
    fill_valid = 1'b0;
    tick();
    if (!keep_valid) data_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      tmp = word >> (dir ? k : (N - 1 - k));
      chk("shift_ctl", 32'(control_signal), dir ? 32'd2 : 32'd1);
      chk("shift_bit", 32'(serial_out), 32'(tmp[0]));
      chk("shift_cnt", 32'(bit_count), 32'(k));
      chk("shift_ready", 32'(data_ready), 32'd0);
      chk("shift_busy", 32'(busy), 32'd1);
      chk("shift_done", 32'(done), 32'd0);
      if (noise) begin
        r          = $urandom;
        data_in    = rnd_word();
        data_dir   = r[0];
        fill_valid = r[1];
        fill_bit   = r[2];
      end
      tick();
    end
    fill_valid = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_ctl", 32'(control_signal), 32'd0);
    chk("done_serial", 32'(serial_out), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(data_ready), 32'd0);
    tick();
    chk("end_ready", 32'(data_ready), 32'd1);
    chk("end_done", 32'(done), 32'd0);
    chk("model_reg", 32'(model_reg), 32'(word));
  endtask

  initial begin
    logic [N-1:0] w;
    logic [31:0]  r;
    rst = 1'b1; data_in = '0; data_dir = 1'b0; data_valid = 1'b0;
    fill_valid = 1'b0; fill_bit = 1'b0;
    tick();
    tick();
    chk("rst_serial", 32'(serial_out), 32'd0);
    chk("rst_ctl", 32'(control_signal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(bit_count), 32'd0);
    rst = 1'b0;

    do_shift(10'h3A0, 1'b0, 1'b0, 1'b0);
    do_shift(10'h3A0, 1'b1, 1'b0, 1'b0);

    // Fill wins over a simultaneous data request; the data waits in IDLE.
    fill_valid = 1'b1; fill_bit = 1'b1;
    data_valid = 1'b1; data_in = 10'h155; data_dir = 1'b1;
    tick();
    fill_valid = 1'b0; fill_bit = 1'b0;
    chk("fill_ctl", 32'(control_signal), 32'd3);
    chk("fill_serial", 32'(serial_out), 32'd1);
    chk("fill_ready", 32'(data_ready), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    tick();
    chk("fill_done", 32'(done), 32'd1);
    chk("fill_done_ctl", 32'(control_signal), 32'd0);
    chk("fill_done_ready", 32'(data_ready), 32'd0);
    tick();
    do_shift(10'h155, 1'b1, 1'b0, 1'b0);

    fill_valid = 1'b1; fill_bit = 1'b0;
    tick();
    fill_valid = 1'b0;
    chk("fill0_ctl", 32'(control_signal), 32'd3);
    chk("fill0_serial", 32'(serial_out), 32'd0);
    tick();
    chk("fill0_done", 32'(done), 32'd1);
    tick();

    do_shift(10'h001, 1'b0, 1'b1, 1'b0);
    do_shift(10'h200, 1'b0, 1'b1, 1'b0);
    data_valid = 1'b0;
    do_shift(10'h001, 1'b1, 1'b1, 1'b0);
    do_shift(10'h3FF, 1'b1, 1'b1, 1'b0);
    data_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      do_shift(rnd_word(), r[0], 1'b0, 1'b1);
    end

    // Reset in the middle of a transfer.
    w = rnd_word();
    data_valid = 1'b1; data_in = w; data_dir = 1'b0;
    tick();
    data_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("mrst_serial", 32'(serial_out), 32'd0);
      chk("mrst_ctl", 32'(control_signal), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_cnt", 32'(bit_count), 32'd0);
    end
    rst = 1'b0;
    chk("mrst_ready", 32'(data_ready), 32'd1);
    for (int j = 0; j < N + 2; j++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      do_shift(rnd_word(), r[0], 1'b0, r[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_loader.md
Name: shift_loader

Overview:
Upstream sequencer for the team's parameterised shift register. It accepts a parallel word over a valid/ready handshake and drives the register's serial_in and 2-bit control_signal for exactly OUTPUT_LENGTH cycles, so the word lands in the register's parallel_out with no bit reversal. It also issues single-cycle fill (load) commands and signals completion to the surrounding controller.

Parameters:
OUTPUT_LENGTH, 10, word width; must equal the downstream shift register's OUTPUT_LENGTH; legal range >= 2.
CNT_W, $clog2(OUTPUT_LENGTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; synchronous, active-high.
data_in  input  OUTPUT_LENGTH  word to load into the shift register.
data_dir  input  1  sampled with data_in: 0 = shift-left load, 1 = shift-right load.
data_valid  input  1  data_in/data_dir valid.
data_ready  output  1  high only in IDLE.
fill_valid  input  1  request to fill the register with fill_bit.
fill_bit  input  1  value for the fill command.
serial_out  output  1  to shift register serial_in.
control_signal  output  2  to shift register control_signal: 00 hold, 01 shift left, 10 shift right, 11 load.
busy  output  1  high in SHIFT, FILL and DONE.
done  output  1  one-cycle pulse when an operation completes.
bit_count  output  CNT_W  number of bits already shifted in the current operation.

Behaviour:
- Reset, applied on a clk edge with rst=1: state=IDLE, serial_out=0, control_signal=00, busy=0, done=0, bit_count=0, captured word and direction cleared.
- Reset takes effect at any state. A transfer interrupted by reset is abandoned; no done pulse is produced.
- All outputs are registered. data_ready and busy are decoded from state only and never depend combinationally on inputs.
- States: IDLE, SHIFT, FILL, DONE.
- IDLE: data_ready=1, control_signal=00.
  - If fill_valid=1, fill has priority over data_valid (data not accepted) and the next state is FILL.
  - Else, if data_valid=1, capture data_in and data_dir, clear bit_count, and go to SHIFT.
- SHIFT runs exactly OUTPUT_LENGTH cycles, indexed k = 0..OUTPUT_LENGTH-1, with bit_count=k.
  - data_dir=0: control_signal=01, serial_out=word[OUTPUT_LENGTH-1-k] (MSB first).
  - data_dir=1: control_signal=10, serial_out=word[k] (LSB first).
  - After the last cycle (bit_count=OUTPUT_LENGTH-1), go to DONE. bit_count saturates at OUTPUT_LENGTH-1 and never wraps.
- FILL lasts one cycle: control_signal=11, serial_out=fill_bit captured in IDLE; then go to DONE.
- DONE lasts one cycle: control_signal=00, done=1, serial_out=0; then go to IDLE.
- data_valid and fill_valid are ignored outside IDLE. Changes to data_in during SHIFT have no effect because the word was captured at acceptance.
- Latency, with acceptance at edge A:
  - SHIFT outputs are present in cycles A+1 .. A+OUTPUT_LENGTH.
  - done is high in cycle A+OUTPUT_LENGTH+1.
  - data_ready is high again in cycle A+OUTPUT_LENGTH+2.
  - Fill: control=11 in cycle A+1, done in A+2.
- Throughput: one word per OUTPUT_LENGTH+2 cycles.
- Invariant: after a completed load, the downstream register's parallel_out equals the accepted data_in for both directions.

Test Plan:
1. rst=1 for 2 cycles mid-SHIFT -> all outputs 0/00, data_ready=1 on the first cycle after rst deasserts, no done pulse.
2. data_in=10'h3A0, data_dir=0 -> control=01 for 10 cycles, serial_out sequence 1,1,1,0,1,0,0,0,0,0, done at cycle A+11, model register holds 10'h3A0.
3. data_in=10'h3A0, data_dir=1 -> control=10 for 10 cycles, serial_out sequence 0,0,0,0,0,1,0,1,1,1, model register holds 10'h3A0.
4. fill_valid=1, fill_bit=1 together with data_valid=1 in IDLE -> one cycle of control=11 with serial_out=1, done next cycle; data_ready stays low, then the held data_valid is accepted on return to IDLE.
5. data_valid held high continuously with words 10'h001 then 10'h200 -> second word accepted at A+OUTPUT_LENGTH+2; bit_count sequence 0..9 for each, never 10.
6. data_in toggled randomly during SHIFT and fill_valid pulsed mid-SHIFT -> shifted bits match the captured word, fill ignored, control never 11.
